npc_branch_unit: RTL and testbench
==================================

// Module: npc_branch_unit
// PURPOSE
//  Fetch-side consumer of the D-stage comparator result: owns the PC register, selects next PC.
//  Inputs: branch (branchop + cmp_out), j/jal, jr, CP0 exception/interrupt entry and eret.
//  Tracks the MIPS delay slot (BD flag for CP0) and flushes F/D on exception entry and eret.
//  Sits between the hazard unit, the D-stage CMP/decoder, CP0 and the instruction memory.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC loaded on reset
//  EXC_VEC   32'h0000_4180  exception/interrupt handler entry
//  IMEM_LO   32'h0000_3000  lowest legal fetch address (used by PC_ALIGN_CHECK_EN)
//  IMEM_HI   32'h0000_6FFC  highest legal fetch address (used by PC_ALIGN_CHECK_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  stall         in   1   hazard unit: freeze PC and F/D register
//  d_branchop    in   3   D-stage branch type, CMP encoding; 0 = not a branch
//  cmp_out       in   1   CMP result for the D-stage branch
//  d_br_target   in   32  PC_D+4+(sext(imm16)<<2)
//  d_jump        in   1   D-stage j/jal
//  d_jump_target in   32  {PC_D[31:28],instr_index,2'b00}
//  d_jr          in   1   D-stage jr/jalr
//  d_jr_target   in   32  forwarded rs value
//  exc_req       in   1   CP0: exception/interrupt taken this cycle
//  eret          in   1   CP0: eret committing this cycle
//  epc           in   32  CP0 EPC
//  pc_f          out  32  current fetch PC
//  pc4_f         out  32  pc_f+4
//  bd_f          out  1   instruction at pc_f is a delay slot
//  flush_fd      out  1   clear F/D register this edge
//  redirect      out  1   control transfer accepted this cycle
//  exc_adel_if   out  1   fetch address error (PC_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (reset=0, async): pc_f=RESET_PC, state=SEQ, bd_f=0, exc_adel_if=0.
//  - flush_fd and redirect are combinational; they are 0 while reset=0.
//  - Next-PC priority, highest first:
//      1. exc_req -> EXC_VEC.
//      2. eret -> epc.
//      3. stall -> hold pc_f.
//      4. d_jr -> d_jr_target.
//      5. d_jump -> d_jump_target.
//      6. (d_branchop!=0 && cmp_out) -> d_br_target.
//      7. else pc_f+4.
//  - exc_req/eret override stall. Both force flush_fd=1 the same cycle. Neither has a delay slot.
//  - Taken transfer (priorities 4-6) never flushes F: the fetched instruction is the delay slot.
//  - redirect=1 only for priorities 4-6 with stall=0.
//  - Not-taken branch: pc+4, no redirect; the following instruction is still a delay slot (BD=1).
//  - FSM states:
//      SEQ  : bd_f=0.
//      SLOT : bd_f=1.
//  - FSM transitions (stall=0 unless noted):
//      SEQ->SLOT  when d_branchop!=0|d_jump|d_jr, taken or not.
//      SLOT->SEQ  otherwise.
//      SLOT->SLOT when the delay slot is itself a branch/jump; the transfer is honoured.
//      stall=1    holds the state.
//      exc_req|eret -> SEQ from any state.
//  - Stall with a taken branch: no PC update, no state change. cmp_out is re-sampled each cycle.
//  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0. Targets are used unmasked.
//  - Simultaneous exc_req and eret: exc_req wins, flush_fd=1.
//  - Reset asserted mid-operation: immediate return to reset values, pending redirect dropped.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//    exc_adel_if registered alongside pc_f.
//    exc_adel_if=1 when the loaded PC has [1:0]!=0 or lies outside [IMEM_LO,IMEM_HI].
//    The PC is still presented; CP0 takes the exception.
//    exc_adel_if is held under stall and cleared by exc_req/eret.
//  PC_ALIGN_CHECK_EN not defined:
//    exc_adel_if tied 0, no range comparators.
// TESTING
//  1. Hold reset=0, then release -> pc_f=0x3000 and bd_f=0; 3 cycles later pc_f=0x300C.
//  2. pc_f=0x3008, d_branchop=1, cmp_out=1, target 0x3100 -> redirect=1; next pc_f=0x3100, bd_f=1 one cycle.
//  3. Same as 2 but cmp_out=0 -> redirect=0; next pc_f=0x300C, bd_f=1 then 0.
//  4. Taken branch with stall=1 for 2 cycles -> pc_f held and redirect=0; stall=0 -> pc_f=0x3100.
//  5. exc_req=1 while stall=1 in SLOT -> pc_f=0x4180, flush_fd=1, bd_f=0.
//     Then eret=1, epc=0x3010 -> pc_f=0x3010, flush_fd=1.
//  6. With PC_ALIGN_CHECK_EN, d_jr_target=0x3002 -> pc_f=0x3002 and exc_adel_if=1.
//     With d_jr_target=0x7000 -> exc_adel_if=1; with 0x3004 -> exc_adel_if=0.

Source files
------------

// File: rtl/npc_branch_unit.sv
// ============================================================================
// npc_branch_unit
// ----------------------------------------------------------------------------
// Fetch-side next-PC selector. Owns the fetch PC register and picks the next
// fetch address from, in descending priority:
//     CP0 exception/interrupt entry, eret, stall (hold), jr/jalr, j/jal,
//     taken conditional branch, and sequential pc+4.
// It also tracks the MIPS branch delay slot so that CP0 can record BD for the
// instruction currently being fetched, and it requests an F/D flush on
// exception entry and eret (neither has a delay slot).
//
// Optional build macro:
//     PC_ALIGN_CHECK_EN - registers a fetch address-error flag alongside the
//                         PC (misaligned or outside [IMEM_LO, IMEM_HI]).
//                         When undefined, exc_adel_if is tied low and no
//                         range comparators are built.
//
// Ports:
//     clk           in   1   clock, rising edge
//     reset         in   1   asynchronous, active-low reset
//     stall         in   1   hazard unit: freeze PC and F/D register
//     d_branchop    in   3   D-stage branch type (0 = not a branch)
//     cmp_out       in   1   comparator result for the D-stage branch
//     d_br_target   in   32  branch target
//     d_jump        in   1   D-stage j/jal
//     d_jump_target in   32  jump target
//     d_jr          in   1   D-stage jr/jalr
//     d_jr_target   in   32  forwarded rs value
//     exc_req       in   1   CP0: exception/interrupt taken this cycle
//     eret          in   1   CP0: eret committing this cycle
//     epc           in   32  CP0 EPC
//     pc_f          out  32  current fetch PC
//     pc4_f         out  32  pc_f + 4 (modulo 2^32)
//     bd_f          out  1   instruction at pc_f is a delay slot
//     flush_fd      out  1   clear F/D register this edge (combinational)
//     redirect      out  1   control transfer accepted this cycle (comb.)
//     exc_adel_if   out  1   fetch address error (PC_ALIGN_CHECK_EN only)
// ============================================================================
module npc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  d_branchop,
    input  logic        cmp_out,
    input  logic [31:0] d_br_target,
    input  logic        d_jump,
    input  logic [31:0] d_jump_target,
    input  logic        d_jr,
    input  logic [31:0] d_jr_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        bd_f,
    output logic        flush_fd,
    output logic        redirect,
    output logic        exc_adel_if
);

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    state_t      state_reg;
    state_t      state_next;

    // ------------------------------------------------------------------------
    // Decode of the D-stage control-transfer request
    // ------------------------------------------------------------------------
    logic is_branch;     // conditional branch present in D
    logic br_taken;      // conditional branch resolved taken
    logic is_xfer;       // any branch/jump in D, taken or not: next is a slot
    logic xfer_taken;    // D-stage transfer actually changes the PC
    logic cp0_entry;     // exc_req or eret: overrides everything incl. stall

    assign is_branch  = (d_branchop != 3'd0);
    assign br_taken   = is_branch && cmp_out;
    assign is_xfer    = is_branch || d_jump || d_jr;
    assign xfer_taken = d_jr || d_jump || br_taken;
    assign cp0_entry  = exc_req || eret;

    // ------------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------------
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (exc_req) begin
            pc_next = EXC_VEC;
        end else if (eret) begin
            pc_next = epc;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (d_jr) begin
            pc_next = d_jr_target;
        end else if (d_jump) begin
            pc_next = d_jump_target;
        end else if (br_taken) begin
            pc_next = d_br_target;
        end
    end

    // ------------------------------------------------------------------------
    // Delay-slot tracking. Any branch/jump in D makes the following fetch a
    // delay slot, whether or not the transfer is taken. A branch sitting in a
    // delay slot keeps us in SLOT and its transfer is still honoured.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (cp0_entry) begin
            state_next = SEQ;
        end else if (!stall) begin
            state_next = is_xfer ? SLOT : SEQ;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // ------------------------------------------------------------------------
    // Fetch address-error check on the PC about to be loaded. The PC is still
    // presented; CP0 decides what to do with the flag.
    // ------------------------------------------------------------------------
    logic adel_reg;
    logic adel_next;

    always_comb begin
        adel_next = (pc_next[1:0] != 2'b00) ||
                    (pc_next < IMEM_LO)     ||
                    (pc_next > IMEM_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adel_reg <= 1'b0;
        end else if (cp0_entry) begin
            adel_reg <= 1'b0;
        end else if (!stall) begin
            adel_reg <= adel_next;
        end
    end

    assign exc_adel_if = adel_reg;
`else
    // Bounds only matter for the optional check; fold them away here.
    logic unused_imem_bounds;
    assign unused_imem_bounds = ^{IMEM_LO, IMEM_HI};
    assign exc_adel_if        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // PC register and FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= RESET_PC;
            state_reg <= SEQ;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. flush/redirect are gated by reset so that a transfer pending at
    // the moment reset asserts is dropped immediately.
    // ------------------------------------------------------------------------
    assign pc_f     = pc_reg;
    assign pc4_f    = pc_reg + 32'd4;
    assign bd_f     = (state_reg == SLOT);
    assign flush_fd = reset && cp0_entry;
    assign redirect = reset && !cp0_entry && !stall && xfer_taken;

endmodule

// File: tb/tb_npc_branch_unit.sv
// ============================================================================
// tb_npc_branch_unit
// ----------------------------------------------------------------------------
// Directed scenarios plus a randomized run, all checked against a small
// behavioural model of the fetch PC, delay-slot flag and address-error flag.
// Inputs change one time unit after the rising edge; registered outputs are
// sampled at that point and combinational outputs one more unit later.
// ============================================================================
`timescale 1ns/1ps
module tb_npc_branch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  d_branchop;
    logic        cmp_out;
    logic [31:0] d_br_target;
    logic        d_jump;
    logic [31:0] d_jump_target;
    logic        d_jr;
    logic [31:0] d_jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        bd_f;
    logic        flush_fd;
    logic        redirect;
    logic        exc_adel_if;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_adel;

    npc_branch_unit #(
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC),
        .IMEM_LO  (IMEM_LO),
        .IMEM_HI  (IMEM_HI)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .d_branchop    (d_branchop),
        .cmp_out       (cmp_out),
        .d_br_target   (d_br_target),
        .d_jump        (d_jump),
        .d_jump_target (d_jump_target),
        .d_jr          (d_jr),
        .d_jr_target   (d_jr_target),
        .exc_req       (exc_req),
        .eret          (eret),
        .epc           (epc),
        .pc_f          (pc_f),
        .pc4_f         (pc4_f),
        .bd_f          (bd_f),
        .flush_fd      (flush_fd),
        .redirect      (redirect),
        .exc_adel_if   (exc_adel_if)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    function automatic logic addr_bad(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return (a % 4 != 0) || (a < IMEM_LO) || (a > IMEM_HI);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic want_redirect();
        if (!reset || exc_req || eret || stall) return 1'b0;
        return d_jr || d_jump || (d_branchop != 0 && cmp_out);
    endfunction

    function automatic logic want_flush();
        return reset && (exc_req || eret);
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_pc = RESET_PC; m_bd = 1'b0; m_adel = 1'b0;
        end else if (exc_req) begin
            m_pc = EXC_VEC; m_bd = 1'b0; m_adel = 1'b0;
        end else if (eret) begin
            m_pc = epc; m_bd = 1'b0; m_adel = 1'b0;
        end else if (!stall) begin
            if (d_jr)                            m_pc = d_jr_target;
            else if (d_jump)                     m_pc = d_jump_target;
            else if (d_branchop != 0 && cmp_out) m_pc = d_br_target;
            else                                 m_pc = m_pc + 4;
            m_bd   = (d_branchop != 0) || d_jump || d_jr;
            m_adel = addr_bad(m_pc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall = 0; d_branchop = 0; cmp_out = 0; d_br_target = 0;
        d_jump = 0; d_jump_target = 0; d_jr = 0; d_jr_target = 0;
        exc_req = 0; eret = 0; epc = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle();
        reset = 0;
        exc_req = 1;      // must not leak out while reset is low
        d_jr = 1; d_jr_target = 32'h0000_3200;
        #1;
        tests_run++;
        if (flush_fd !== 1'b0 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_comb flush=%b redirect=%b want 0/0", flush_fd, redirect);
        end
        tick();
        tick();
        idle();
        reset = 1;
        tests_run++;
        if (pc_f !== RESET_PC || bd_f !== 1'b0 || exc_adel_if !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state pc=%h bd=%b adel=%b want %h/0/0", pc_f, bd_f, exc_adel_if, RESET_PC);
        end
        tick(); tick(); tick();
        tests_run++;
        if (pc_f !== 32'h0000_300C || pc4_f !== 32'h0000_3010) begin
            tests_failed++;
            $display("FAIL reset_seq pc=%h pc4=%h want 0000300c/00003010", pc_f, pc4_f);
        end
        $display("[TB] test_reset pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_branch_taken();
        do_reset();
        tick(); tick();                       // pc = 0x3008
        d_branchop = 3'd1; cmp_out = 1; d_br_target = 32'h0000_3100;
        #1;
        tests_run++;
        if (redirect !== 1'b1 || flush_fd !== 1'b0) begin
            tests_failed++;
            $display("FAIL taken_redirect redirect=%b flush=%b want 1/0", redirect, flush_fd);
        end
        tick();
        idle();
        tests_run++;
        if (pc_f !== 32'h0000_3100 || bd_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL taken_target pc=%h bd=%b want 00003100/1", pc_f, bd_f);
        end
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_3104 || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL taken_after pc=%h bd=%b want 00003104/0", pc_f, bd_f);
        end
        $display("[TB] test_branch_taken pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        tick(); tick();
        d_branchop = 3'd1; cmp_out = 0; d_br_target = 32'h0000_3100;
        #1;
        tests_run++;
        if (redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL nt_redirect redirect=%b want 0", redirect);
        end
        tick();
        idle();
        tests_run++;
        if (pc_f !== 32'h0000_300C || bd_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL nt_slot pc=%h bd=%b want 0000300c/1", pc_f, bd_f);
        end
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_3010 || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL nt_after pc=%h bd=%b want 00003010/0", pc_f, bd_f);
        end
        $display("[TB] test_branch_not_taken pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_stall_branch();
        do_reset();
        tick(); tick();
        d_branchop = 3'd2; cmp_out = 1; d_br_target = 32'h0000_3100; stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (redirect !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_redirect cyc=%0d redirect=%b want 0", i, redirect);
            end
            tick();
            tests_run++;
            if (pc_f !== 32'h0000_3008 || bd_f !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d pc=%h bd=%b want 00003008/0", i, pc_f, bd_f);
            end
        end
        stall = 0;
        tick();
        idle();
        tests_run++;
        if (pc_f !== 32'h0000_3100 || bd_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release pc=%h bd=%b want 00003100/1", pc_f, bd_f);
        end
        $display("[TB] test_stall_branch pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_exc_eret();
        do_reset();
        tick(); tick();
        d_jump = 1; d_jump_target = 32'h0000_3100;
        tick();                               // now in a delay slot
        idle();
        stall = 1; exc_req = 1; d_jr = 1; d_jr_target = 32'h0000_3500;
        #1;
        tests_run++;
        if (flush_fd !== 1'b1 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL exc_comb flush=%b redirect=%b want 1/0", flush_fd, redirect);
        end
        tick();
        idle();
        tests_run++;
        if (pc_f !== EXC_VEC || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL exc_entry pc=%h bd=%b want %h/0", pc_f, bd_f, EXC_VEC);
        end
        eret = 1; epc = 32'h0000_3010;
        #1;
        tests_run++;
        if (flush_fd !== 1'b1) begin
            tests_failed++;
            $display("FAIL eret_flush flush=%b want 1", flush_fd);
        end
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_3010 || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL eret_pc pc=%h bd=%b want 00003010/0", pc_f, bd_f);
        end
        // exc_req and eret together: exception vector wins
        eret = 1; exc_req = 1; epc = 32'h0000_3020;
        #1;
        tests_run++;
        if (flush_fd !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_flush flush=%b want 1", flush_fd);
        end
        tick();
        idle();
        tests_run++;
        if (pc_f !== EXC_VEC) begin
            tests_failed++;
            $display("FAIL both_pc pc=%h want %h", pc_f, EXC_VEC);
        end
        $display("[TB] test_exc_eret pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_jump = 1; d_jump_target = 32'h0000_3400;
        tick();
        idle();
        d_jr = 1; d_jr_target = 32'h0000_3800;   // transfer sitting in the slot
        tick();
        idle();
        tests_run++;
        if (pc_f !== 32'h0000_3800 || bd_f !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_slot pc=%h bd=%b want 00003800/1", pc_f, bd_f);
        end
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_3804 || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_after pc=%h bd=%b want 00003804/0", pc_f, bd_f);
        end
        $display("[TB] test_back_to_back pc=%h bd=%b", pc_f, bd_f);
    endtask

    task automatic test_wrap();
        do_reset();
        d_jr = 1; d_jr_target = 32'hFFFF_FFFC;
        tick();
        idle();
        tests_run++;
        if (pc4_f !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_pc4 pc4=%h want 00000000", pc4_f);
        end
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_pc pc=%h want 00000000", pc_f);
        end
        $display("[TB] test_wrap pc=%h", pc_f);
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tick();
        d_branchop = 3'd3; cmp_out = 1; d_br_target = 32'h0000_3700;
        #2;
        reset = 0;                            // between edges
        m_pc = RESET_PC; m_bd = 1'b0; m_adel = 1'b0;
        #1;
        tests_run++;
        if (pc_f !== RESET_PC || redirect !== 1'b0 || bd_f !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset pc=%h redirect=%b bd=%b want %h/0/0", pc_f, redirect, bd_f, RESET_PC);
        end
        tick();
        idle();
        reset = 1;
        tick();
        tests_run++;
        if (pc_f !== 32'h0000_3004) begin
            tests_failed++;
            $display("FAIL async_resume pc=%h want 00003004", pc_f);
        end
        $display("[TB] test_async_reset pc=%h", pc_f);
    endtask

    task automatic test_align();
        logic [31:0] tgt [3];
        logic        want [3];
        tgt[0] = 32'h0000_3002; tgt[1] = 32'h0000_7000; tgt[2] = 32'h0000_3004;
`ifdef PC_ALIGN_CHECK_EN
        want[0] = 1'b1; want[1] = 1'b1; want[2] = 1'b0;
`else
        want[0] = 1'b0; want[1] = 1'b0; want[2] = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            d_jr = 1; d_jr_target = tgt[i];
            tick();
            tests_run++;
            if (pc_f !== tgt[i] || exc_adel_if !== want[i]) begin
                tests_failed++;
                $display("FAIL align_%0d pc=%h adel=%b want %h/%b", i, pc_f, exc_adel_if, tgt[i], want[i]);
            end
            $display("[TB] test_align target=%h adel=%b", tgt[i], exc_adel_if);
        end
        idle();
    endtask

    task automatic test_random();
        logic exp_r;
        logic exp_f;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            exc_req       = ($urandom_range(0, 15) == 0);
            eret          = ($urandom_range(0, 15) == 0);
            d_branchop    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            cmp_out       = 1'($urandom);
            d_jump        = ($urandom_range(0, 5) == 0);
            d_jr          = ($urandom_range(0, 5) == 0);
            d_br_target   = IMEM_LO + 32'($urandom_range(0, 4095)) * 4;
            d_jump_target = IMEM_LO + 32'($urandom_range(0, 4095)) * 4;
            d_jr_target   = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                        : IMEM_LO + 32'($urandom_range(0, 4095)) * 4;
            epc           = IMEM_LO + 32'($urandom_range(0, 4095)) * 4;
            #1;
            exp_r = want_redirect();
            exp_f = want_flush();
            tests_run++;
            if (redirect !== exp_r || flush_fd !== exp_f) begin
                tests_failed++;
                $display("FAIL rnd_comb n=%0d redirect=%b flush=%b want %b/%b", n, redirect, flush_fd, exp_r, exp_f);
            end
            tick();
            tests_run++;
            if (pc_f !== m_pc || pc4_f !== m_pc + 32'd4 || bd_f !== m_bd || exc_adel_if !== m_adel) begin
                tests_failed++;
                $display("FAIL rnd_state n=%0d pc=%h pc4=%h bd=%b adel=%b want %h/%h/%b/%b",
                         n, pc_f, pc4_f, bd_f, exc_adel_if, m_pc, m_pc + 32'd4, m_bd, m_adel);
            end
            $display("[TB] rnd n=%0d pc=%h bd=%b adel=%b", n, pc_f, bd_f, exc_adel_if);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 0;
        m_pc = RESET_PC; m_bd = 1'b0; m_adel = 1'b0;
        test_reset();
        test_branch_taken();
        test_branch_not_taken();
        test_stall_branch();
        test_exc_eret();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
